lfsr_prbs_checker: RTL
======================

# lfsr_prbs_checker

Receive-side PRBS checker for word streams produced by the team's parameterised Galois LFSR generator (`shifter_lfsr_galois`). It self-synchronises to the incoming words and then free-runs its own reference LFSR. It reports lock status and counts mismatching words. It sits at the far end of a link or datapath under test, fed with the same tap vector and width as the transmitting generator.

## Interface
Parameters:
- `WIDTH`, 8: LFSR / data word width; minimum 2.
- `TAP_INDEX_WIDTH`, 12: bits per packed tap position (TIW).
- `TAP_COUNT`, 4: number of tap fields in `i_taps`.
- `LOCK_COUNT`, 4: consecutive predicted matches needed to declare lock; minimum 1.
- `UNLOCK_COUNT`, 4: consecutive locked mismatches that drop lock; minimum 1.
- `COUNT_WIDTH`, 32: width of the error and word counters; minimum 2.

Ports:
- `i_clk`, in, 1: clock; all state changes on its rising edge.
- `i_rst_n`, in, 1: reset, asynchronous and active-low.
- `i_enable`, in, 1: when low, all state holds and `o_err` is 0.
- `i_clear`, in, 1: synchronous clear; acts even when `i_enable` is low.
- `i_taps`, in, TAP_COUNT*TIW: packed tap positions; field k = `i_taps[k*TIW +: TIW]`.
- `i_valid`, in, 1: `i_data` holds a word to check this cycle.
- `i_data`, in, WIDTH: received LFSR word.
- `o_locked`, out, 1: checker is in the LOCKED state.
- `o_err`, out, 1: registered one-cycle pulse for a locked mismatch.
- `o_err_count`, out, COUNT_WIDTH: saturating count of locked mismatches.
- `o_word_count`, out, COUNT_WIDTH: saturating count of words checked while locked.

## Operation
- `step(s)` must match the generator bit-exactly.
  - Start from n = {s[WIDTH-2:0], s[WIDTH-1]}.
  - For every tap field t with 1 <= t <= WIDTH: n[t-1] = s[WIDTH-1] ^ s[t-1].
  - Tap fields equal to 0 or greater than WIDTH are ignored. Duplicate taps are harmless.
- States: HUNT (reset state) and LOCKED. Internal registers:
  - `prev` (WIDTH) and `have_prev` (1).
  - `expected` (WIDTH).
  - `match_cnt` (0..LOCK_COUNT) and `miss_cnt` (0..UNLOCK_COUNT).
- In HUNT, on each `i_valid` with `i_enable` high:
  - A match requires `have_prev` = 1, `i_data` == step(`prev`), and `i_data` != 0. A match increments `match_cnt`; anything else sets `match_cnt` to 0.
  - `prev` <= `i_data` and `have_prev` <= 1.
  - When a match brings `match_cnt` to LOCK_COUNT: go to LOCKED, `expected` <= step(`i_data`), `miss_cnt` <= 0.
  - HUNT never touches `o_err`, `o_err_count` or `o_word_count`.
- In LOCKED, on each `i_valid` with `i_enable` high:
  - `expected` <= step(`expected`) unconditionally. The reference free-runs, so a bad word does not corrupt later predictions.
  - `o_word_count` increments, saturating at all-ones.
  - On mismatch (`i_data` != `expected`): `o_err` <= 1, `o_err_count` increments (saturating), `miss_cnt` increments.
  - On match: `miss_cnt` <= 0.
  - When a mismatch brings `miss_cnt` to UNLOCK_COUNT: go to HUNT, `match_cnt` <= 0, `prev` <= `i_data`, `have_prev` <= 1. The unlocking mismatch itself is still counted and pulsed.
- `i_valid` low: no state change, and `o_err` is 0 next cycle.
- `i_clear` has priority over everything except reset:
  - Go to HUNT; `have_prev`, `match_cnt`, `miss_cnt` <= 0.
  - Both counters <= 0; `o_err` <= 0.
  - The word presented in the same cycle is discarded.
- Changes to `i_taps` take effect on the next step() evaluation. Software must pulse `i_clear` after changing taps.
- Reset values:
  - State HUNT; `o_locked` 0, `o_err` 0, both counters 0.
  - `have_prev` 0; `prev` and `expected` all-ones; `match_cnt` and `miss_cnt` 0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `o_locked` rises in the cycle after the edge that accepts the LOCK_COUNT-th consecutive match. It falls after the edge that accepts the UNLOCK_COUNT-th consecutive mismatch.
- The first word checked in LOCKED is the next valid word after the locking word.
- `o_err` and counter updates appear one cycle after the offending word is sampled.
- Back-to-back valid words are accepted every cycle (throughput 1 word/clock). Gaps in `i_valid` do not advance the reference.
- Reset asserted mid-operation immediately forces all reset values. The first word after deassertion starts a fresh HUNT.

## Test plan
All tests use WIDTH=8, taps field0=1 and the others 0 (`i_taps`=48'h000000000001). Generator sequence: 01,03,07,0F,1F,3F,7F,FF,FE,FD.
- Lock: feed 01,03,07,0F,1F back-to-back -> `o_locked` 1 the cycle after 1F. Counters stay 0, `o_err` never pulses.
- Single error: after lock, feed 3F,00,FF,FE -> one `o_err` pulse the cycle after 00. `o_err_count`=1, `o_word_count`=4, `o_locked` stays 1 (reference is free-running).
- Loss of lock: after lock, feed four words of 55 -> four `o_err` pulses, `o_err_count`=4, `o_locked` drops after the fourth. Then feed 01,03,07,0F,1F -> relock.
- Zero stream: feed 00 for 20 cycles from reset -> `o_locked` stays 0 and all counters stay 0.
- Gaps and clear: lock with `i_valid` toggling every other cycle -> same result as back-to-back. Then assert `i_clear` with `i_valid` high -> HUNT, counters 0, and the presented word is ignored.
- Saturation and reset: COUNT_WIDTH=2, locked, six mismatching words with UNLOCK_COUNT=8 -> `o_err_count` holds 3. Then assert `i_rst_n` low mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/lfsr_prbs_checker.sv
// Receive-side PRBS checker for Galois LFSR word streams: self-synchronises on
// consecutive predicted words, then free-runs a reference and counts mismatches.
module lfsr_prbs_checker #(
   parameter int WIDTH           = 8,
   parameter int TAP_INDEX_WIDTH = 12,
   parameter int TAP_COUNT       = 4,
   parameter int LOCK_COUNT      = 4,
   parameter int UNLOCK_COUNT    = 4,
   parameter int COUNT_WIDTH     = 32
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst_n,
   input  logic                                   i_enable,
   input  logic                                   i_clear,
   input  logic [TAP_COUNT*TAP_INDEX_WIDTH-1:0]   i_taps,
   input  logic                                   i_valid,
   input  logic [WIDTH-1:0]                       i_data,
   output logic                                   o_locked,
   output logic                                   o_err,
   output logic [COUNT_WIDTH-1:0]                 o_err_count,
   output logic [COUNT_WIDTH-1:0]                 o_word_count
);

   localparam int TIW = TAP_INDEX_WIDTH;
   localparam int MCW = $clog2(LOCK_COUNT + 1);
   localparam int XCW = $clog2(UNLOCK_COUNT + 1);
   localparam logic [MCW-1:0] LOCK_TARGET   = MCW'(LOCK_COUNT);
   localparam logic [XCW-1:0] UNLOCK_TARGET = XCW'(UNLOCK_COUNT);

   localparam logic [0:0] ST_HUNT   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]             state_reg, state_next;
   logic [WIDTH-1:0]       prev_reg, prev_next;
   logic                   have_prev_reg, have_prev_next;
   logic [WIDTH-1:0]       expected_reg, expected_next;
   logic [MCW-1:0]         match_cnt_reg, match_cnt_next;
   logic [XCW-1:0]         miss_cnt_reg, miss_cnt_next;
   logic                   err_reg, err_next;
   logic [COUNT_WIDTH-1:0] err_count_reg, err_count_next;
   logic [COUNT_WIDTH-1:0] word_count_reg, word_count_next;

   logic [WIDTH-1:0]       tap_mask;
   logic [WIDTH-1:0]       step_prev, step_data, step_expected;
   logic [MCW-1:0]         match_inc;
   logic [XCW-1:0]         miss_inc;
   logic                   hunt_match;

   // Bit gi is a feedback tap if any tap field names position gi+1; 0 and
   // out-of-range fields never hit, duplicates just hit twice.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap_mask
         logic hit;
         always_comb begin
            hit = 1'b0;
            for (int k = 0; k < TAP_COUNT; k++) begin
               if (i_taps[k*TIW +: TIW] == TIW'(gi + 1)) hit = 1'b1;
            end
         end
         assign tap_mask[gi] = hit;
      end
   endgenerate

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] mask);
      logic [WIDTH-1:0] n;
      n = {s[WIDTH-2:0], s[WIDTH-1]};
      for (int b = 0; b < WIDTH; b++) begin
         if (mask[b]) n[b] = s[WIDTH-1] ^ s[b];
      end
      return n;
   endfunction

   assign step_prev     = lfsr_step(prev_reg, tap_mask);
   assign step_data     = lfsr_step(i_data, tap_mask);
   assign step_expected = lfsr_step(expected_reg, tap_mask);
   assign match_inc     = match_cnt_reg + 1'b1;
   assign miss_inc      = miss_cnt_reg + 1'b1;
   assign hunt_match    = have_prev_reg && (i_data == step_prev) && (i_data != '0);

   always_comb begin
      state_next      = state_reg;
      prev_next       = prev_reg;
      have_prev_next  = have_prev_reg;
      expected_next   = expected_reg;
      match_cnt_next  = match_cnt_reg;
      miss_cnt_next   = miss_cnt_reg;
      err_next        = 1'b0;
      err_count_next  = err_count_reg;
      word_count_next = word_count_reg;

      if (i_clear) begin
         state_next      = ST_HUNT;
         have_prev_next  = 1'b0;
         match_cnt_next  = '0;
         miss_cnt_next   = '0;
         err_count_next  = '0;
         word_count_next = '0;
      end else if (i_enable && i_valid) begin
         if (state_reg == ST_HUNT) begin
            prev_next      = i_data;
            have_prev_next = 1'b1;
            if (hunt_match) begin
               match_cnt_next = match_inc;
               if (match_inc == LOCK_TARGET) begin
                  state_next    = ST_LOCKED;
                  expected_next = step_data;
                  miss_cnt_next = '0;
               end
            end else begin
               match_cnt_next = '0;
            end
         end else begin
            // Reference free-runs so one corrupted word cannot derail later checks.
            expected_next = step_expected;
            if (~&word_count_reg) word_count_next = word_count_reg + 1'b1;
            if (i_data != expected_reg) begin
               err_next      = 1'b1;
               miss_cnt_next = miss_inc;
               if (~&err_count_reg) err_count_next = err_count_reg + 1'b1;
               if (miss_inc == UNLOCK_TARGET) begin
                  state_next     = ST_HUNT;
                  match_cnt_next = '0;
                  prev_next      = i_data;
                  have_prev_next = 1'b1;
               end
            end else begin
               miss_cnt_next = '0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg      <= ST_HUNT;
         prev_reg       <= '1;
         have_prev_reg  <= 1'b0;
         expected_reg   <= '1;
         match_cnt_reg  <= '0;
         miss_cnt_reg   <= '0;
         err_reg        <= 1'b0;
         err_count_reg  <= '0;
         word_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         prev_reg       <= prev_next;
         have_prev_reg  <= have_prev_next;
         expected_reg   <= expected_next;
         match_cnt_reg  <= match_cnt_next;
         miss_cnt_reg   <= miss_cnt_next;
         err_reg        <= err_next;
         err_count_reg  <= err_count_next;
         word_count_reg <= word_count_next;
      end
   end

   assign o_locked     = (state_reg == ST_LOCKED);
   assign o_err        = err_reg;
   assign o_err_count  = err_count_reg;
   assign o_word_count = word_count_reg;

endmodule
